// File: rtl/stack_cmd_pkg.sv
// Shared encodings for the stack command front-end: op codes, response
// error codes, the controller FSM state type and the command screening rule.
package stack_cmd_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WAIT = 2'b10,
        RSP  = 2'b11
    } state_t;

    // Error code for an op given the stack flags sampled in EXEC.
    function automatic logic [1:0] screen_op(input logic [1:0] op,
                                             input logic       full,
                                             input logic       empty);
        logic [1:0] err;
        case (op)
            OP_NOP:  err = ERR_OK;
            OP_PUSH: err = full  ? ERR_OVF : ERR_OK;
            OP_POP:  err = empty ? ERR_UNF : ERR_OK;
            default: err = ERR_ILL;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/stack_cmd_occ_cnt.sv
// Occupancy counter tracking the stack fill level from the push/pop strobes.
// Only instantiated when STACK_CMD_CTRL_OCC_EN is defined.
module stack_cmd_occ_cnt #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int             OCC_W   = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    // Count up on push, down on pop, clamped to 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (inc && !dec && (occ != OCC_MAX)) begin
            occ <= occ + 1'b1;
        end else if (dec && !inc && (occ != '0)) begin
            occ <= occ - 1'b1;
        end
    end

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Command front-end for the LIFO stack: accepts PUSH/POP/NOP commands,
// screens them against the stack flags, strobes the stack and returns one
// response per command with a fixed 3-cycle latency.
// Optional feature macro: STACK_CMD_CTRL_OCC_EN adds the occ port and counter.
module stack_cmd_ctrl
    import stack_cmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [1:0]                   rsp_err,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [WIDTH-1:0]             stk_din,
    input  logic [WIDTH-1:0]             stk_dout,
    input  logic                         stk_empty,
    input  logic                         stk_full
`ifdef STACK_CMD_CTRL_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`endif
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("stack_cmd_ctrl: DEPTH must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             push_ok_q;
    logic             pop_ok_q;
    logic             accept;
    logic             push_ok;
    logic             pop_ok;
    logic [1:0]       err_eval;

    // Next state and all combinational outputs; strobes and cmd_ready are
    // masked during reset so an abandoned command can never touch the stack.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        accept    = 1'b0;
        push_ok   = 1'b0;
        pop_ok    = 1'b0;
        err_eval  = ERR_OK;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                err_eval  = screen_op(op_q, stk_full, stk_empty);
                push_ok   = (op_q == OP_PUSH) && !stk_full;
                pop_ok    = (op_q == OP_POP) && !stk_empty;
                stk_push  = push_ok && !rst;
                stk_pop   = pop_ok && !rst;
                stk_din   = (push_ok && !rst) ? data_q : '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the accepted command; only read back in EXEC/WAIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    // Record the screening outcome in EXEC for use in WAIT and RSP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err   <= ERR_OK;
            push_ok_q <= 1'b0;
            pop_ok_q  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_err   <= err_eval;
            push_ok_q <= push_ok;
            pop_ok_q  <= pop_ok;
        end
    end

    // Load response data in WAIT, once the stack's registered dout is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
        end else if (state == WAIT) begin
            if (pop_ok_q) begin
                rsp_data <= stk_dout;
            end else if (push_ok_q) begin
                rsp_data <= data_q;
            end else begin
                rsp_data <= '0;
            end
        end
    end

`ifdef STACK_CMD_CTRL_OCC_EN
    stack_cmd_occ_cnt #(
        .DEPTH (DEPTH)
    ) u_occ_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stk_push),
        .dec (stk_pop),
        .occ (occ)
    );
`endif

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Testbench for stack_cmd_ctrl with a small behavioural LIFO stack below it.
// Occupancy checks are included when STACK_CMD_CTRL_OCC_EN is defined.
module tb_stack_cmd_ctrl;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
    logic       stk_empty;
    logic       stk_full;
`ifdef STACK_CMD_CTRL_OCC_EN
    logic [3:0] occ;
`endif

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    int both_cnt = 0;

    typedef struct {
        logic       p1;
        logic       q1;
        logic       r1;
        logic [7:0] din1;
        logic       v2;
        logic       v3;
        logic [7:0] d;
        logic [1:0] e;
        int         np;
        int         nq;
        int         waits;
    } obs_t;

    stack_cmd_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .stk_empty (stk_empty),
        .stk_full  (stk_full)
`ifdef STACK_CMD_CTRL_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 8-deep stack with registered dout, reset by the same rst.
    logic [7:0] mem [8];
    logic [3:0] sp;
    assign stk_empty = (sp == 4'd0);
    assign stk_full  = (sp == 4'd8);

    always @(posedge clk) begin
        if (rst) begin
            sp       <= 4'd0;
            stk_dout <= 8'h00;
        end else if (stk_push) begin
            mem[sp[2:0]] <= stk_din;
            sp           <= sp + 4'd1;
        end else if (stk_pop) begin
            stk_dout <= mem[3'(sp - 4'd1)];
            sp       <= sp - 4'd1;
        end
    end

    // Strobe tallies sampled at each active edge.
    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop)  pop_cnt  <= pop_cnt + 1;
        if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one command with rsp_ready as currently driven; observe the
    // accept-to-response timeline. Returns in the cycle after the response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, output obs_t o);
        bit got;
        int p0;
        int q0;
        o = '{default: '0};
        cmd_op = op;
        cmd_data = data;
        cmd_valid = 1'b1;
        got = 1'b0;
        while (!got && o.waits < 20) begin
            #1;
            if (cmd_ready) got = 1'b1;
            else begin
                o.waits++;
                step();
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, o.waits);
            cmd_valid = 1'b0;
            return;
        end
        p0 = push_cnt;
        q0 = pop_cnt;
        step();
        cmd_valid = 1'b0;
        cmd_op = OP_NOP;
        #1;
        o.p1 = stk_push;
        o.q1 = stk_pop;
        o.din1 = stk_din;
        o.r1 = cmd_ready;
        step();
        o.v2 = rsp_valid;
        step();
        o.v3 = rsp_valid;
        o.d = rsp_data;
        o.e = rsp_err;
        o.np = push_cnt - p0;
        o.nq = pop_cnt - q0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got %0b required 0", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %0b required 0", rsp_valid); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL rst_rsp_data: got %0h required 00", rsp_data); end
        total++; if (rsp_err !== 2'b00) begin bad++; $display("FAIL rst_rsp_err: got %0b required 00", rsp_err); end
        total++; if ({stk_push, stk_pop} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %0b required 00", {stk_push, stk_pop}); end
        total++; if (stk_din !== 8'h00) begin bad++; $display("FAIL rst_stk_din: got %0h required 00", stk_din); end
        rst = 1'b0;
        step();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cmd_ready: got %0b required 1", cmd_ready); end
`ifdef STACK_CMD_CTRL_OCC_EN
        total++; if (occ !== 4'd0) begin bad++; $display("FAIL rst_occ: got %0d required 0", occ); end
`endif
    endtask

    task automatic test_push_pop();
        obs_t o;
        run_cmd(OP_PUSH, 8'h5A, o);
        total++; if (o.p1 !== 1'b1 || o.q1 !== 1'b0) begin bad++; $display("FAIL push_strobe: got push=%0b pop=%0b required 1/0", o.p1, o.q1); end
        total++; if (o.din1 !== 8'h5A) begin bad++; $display("FAIL push_din: got %0h required 5a", o.din1); end
        total++; if (o.r1 !== 1'b0) begin bad++; $display("FAIL push_busy_ready: got %0b required 0", o.r1); end
        total++; if (o.v2 !== 1'b0 || o.v3 !== 1'b1) begin bad++; $display("FAIL push_latency: got v2=%0b v3=%0b required 0/1", o.v2, o.v3); end
        total++; if (o.d !== 8'h5A || o.e !== 2'b00) begin bad++; $display("FAIL push_rsp: got d=%0h e=%0b required 5a/00", o.d, o.e); end
        total++; if (o.np !== 1) begin bad++; $display("FAIL push_count: got %0d strobes required 1", o.np); end
`ifdef STACK_CMD_CTRL_OCC_EN
        total++; if (occ !== 4'd1) begin bad++; $display("FAIL push_occ: got %0d required 1", occ); end
`endif
        run_cmd(OP_POP, 8'hC3, o);
        total++; if (o.waits !== 0) begin bad++; $display("FAIL back_to_back: got %0d wait cycles required 0", o.waits); end
        total++; if (o.q1 !== 1'b1 || o.p1 !== 1'b0) begin bad++; $display("FAIL pop_strobe: got push=%0b pop=%0b required 0/1", o.p1, o.q1); end
        total++; if (o.d !== 8'h5A || o.e !== 2'b00) begin bad++; $display("FAIL pop_rsp: got d=%0h e=%0b required 5a/00", o.d, o.e); end
        total++; if (o.nq !== 1 || o.np !== 0) begin bad++; $display("FAIL pop_count: got pops=%0d pushes=%0d required 1/0", o.nq, o.np); end
`ifdef STACK_CMD_CTRL_OCC_EN
        total++; if (occ !== 4'd0) begin bad++; $display("FAIL pop_occ: got %0d required 0", occ); end
`endif
    endtask

    task automatic test_pop_empty();
        obs_t o;
        run_cmd(OP_POP, 8'h00, o);
        total++; if (o.q1 !== 1'b0 || o.nq !== 0) begin bad++; $display("FAIL unf_strobe: got pop=%0b count=%0d required 0/0", o.q1, o.nq); end
        total++; if (o.d !== 8'h00 || o.e !== 2'b10) begin bad++; $display("FAIL unf_rsp: got d=%0h e=%0b required 00/10", o.d, o.e); end
        run_cmd(OP_NOP, 8'h44, o);
        total++; if (o.d !== 8'h00 || o.e !== 2'b00 || o.np !== 0 || o.nq !== 0) begin bad++; $display("FAIL nop_rsp: got d=%0h e=%0b np=%0d nq=%0d required 00/00/0/0", o.d, o.e, o.np, o.nq); end
    endtask

    task automatic test_fill_overflow();
        obs_t o;
        for (int i = 1; i <= 8; i++) begin
            run_cmd(OP_PUSH, 8'(i), o);
            total++; if (o.d !== 8'(i) || o.e !== 2'b00 || o.np !== 1) begin bad++; $display("FAIL fill_%0d: got d=%0h e=%0b np=%0d required %0h/00/1", i, o.d, o.e, o.np, i); end
        end
        run_cmd(OP_PUSH, 8'h09, o);
        total++; if (o.e !== 2'b01 || o.d !== 8'h00) begin bad++; $display("FAIL ovf_rsp: got d=%0h e=%0b required 00/01", o.d, o.e); end
        total++; if (o.p1 !== 1'b0 || o.np !== 0) begin bad++; $display("FAIL ovf_strobe: got push=%0b count=%0d required 0/0", o.p1, o.np); end
`ifdef STACK_CMD_CTRL_OCC_EN
        total++; if (occ !== 4'd8) begin bad++; $display("FAIL ovf_occ: got %0d required 8", occ); end
`endif
        for (int i = 8; i >= 1; i--) begin
            run_cmd(OP_POP, 8'h00, o);
            total++; if (o.d !== 8'(i) || o.e !== 2'b00 || o.nq !== 1) begin bad++; $display("FAIL drain_%0d: got d=%0h e=%0b nq=%0d required %0h/00/1", i, o.d, o.e, o.nq, i); end
        end
    endtask

    task automatic test_illegal_stall();
        obs_t o;
        int p0;
        int q0;
        rsp_ready = 1'b0;
        p0 = push_cnt;
        q0 = pop_cnt;
        run_cmd(OP_ILL, 8'hFF, o);
        total++; if (o.v3 !== 1'b1 || o.d !== 8'h00 || o.e !== 2'b11) begin bad++; $display("FAIL ill_rsp: got v=%0b d=%0h e=%0b required 1/00/11", o.v3, o.d, o.e); end
        total++; if (o.p1 !== 1'b0 || o.q1 !== 1'b0) begin bad++; $display("FAIL ill_strobe: got push=%0b pop=%0b required 0/0", o.p1, o.q1); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_err !== 2'b11 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_%0d: got v=%0b d=%0h e=%0b rdy=%0b required 1/00/11/0", i, rsp_valid, rsp_data, rsp_err, cmd_ready);
            end
            step();
        end
        total++; if (push_cnt !== p0 || pop_cnt !== q0) begin bad++; $display("FAIL stall_strobes: got %0d pushes %0d pops required 0/0", push_cnt - p0, pop_cnt - q0); end
        rsp_ready = 1'b1;
        step();
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got rdy=%0b v=%0b required 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_rst_mid();
        obs_t o;
        int p0;
        int seen;
        run_cmd(OP_PUSH, 8'h33, o);
        total++; if (o.e !== 2'b00 || o.d !== 8'h33) begin bad++; $display("FAIL pre_rst_push: got d=%0h e=%0b required 33/00", o.d, o.e); end
        cmd_op = OP_PUSH;
        cmd_data = 8'h77;
        cmd_valid = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_accept: got rdy=%0b required 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        p0 = push_cnt;
        #1;
        total++; if (stk_push !== 1'b0) begin bad++; $display("FAIL mid_rst_strobe: got %0b required 0", stk_push); end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 2'b00 || stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_din !== 8'h00) begin
            bad++;
            $display("FAIL mid_rst_outputs: got v=%0b d=%0h e=%0b push=%0b pop=%0b din=%0h required all 0", rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_din);
        end
`ifdef STACK_CMD_CTRL_OCC_EN
        total++; if (occ !== 4'd0) begin bad++; $display("FAIL mid_rst_occ: got %0d required 0", occ); end
`endif
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            step();
        end
        total++; if (seen !== 0 || push_cnt !== p0) begin bad++; $display("FAIL mid_rst_abandon: got %0d rsp cycles %0d pushes required 0/0", seen, push_cnt - p0); end
        run_cmd(OP_POP, 8'h00, o);
        total++; if (o.e !== 2'b10 || o.d !== 8'h00 || o.nq !== 0) begin bad++; $display("FAIL post_rst_pop: got d=%0h e=%0b nq=%0d required 00/10/0", o.d, o.e, o.nq); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_fill_overflow();
        test_illegal_stall();
        test_rst_mid();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL dual_strobe: got %0d cycles with both strobes required 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_cmd_ctrl.md
# stack_cmd_ctrl

Command front-end for the LIFO stack. Accepts PUSH/POP/NOP commands over a valid/ready handshake, screens each against the stack's full/empty flags, drives single-cycle push/pop strobes into the stack, and returns one response per command (data plus error code) over a second valid/ready handshake. It sits directly upstream of the stack and consumes its registered `dout`.

## Interface
- `WIDTH`, 8, data width; must equal the stack's `WIDTH`.
- `DEPTH`, 8, stack depth; must equal the stack's `DEPTH`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 NOP, 01 PUSH, 10 POP, 11 illegal.
- `cmd_data`  in  WIDTH  push data; ignored for other ops.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  WIDTH  popped value, echoed push value, or 0.
- `rsp_err`  out  2  00 OK, 01 overflow, 10 underflow, 11 illegal op.
- `stk_push`, `stk_pop`  out  1  strobes to the stack, never both high.
- `stk_din`  out  WIDTH  data to the stack.
- `stk_dout`  in  WIDTH  stack's registered output.
- `stk_empty`, `stk_full`  in  1  stack flags.
- `occ`  out  $clog2(DEPTH+1)  occupancy; present only under `STACK_CMD_CTRL_OCC_EN`.

## Operation
- FSM states: IDLE, EXEC, WAIT, RSP. Reset enters IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch op and data, then go to EXEC.
- EXEC: evaluate the latched op against the current flags, then go to WAIT.
  - PUSH with `!stk_full`: `stk_push`=1, `stk_din`=latched data, err OK.
  - PUSH with `stk_full`: no strobe, err 01.
  - POP with `!stk_empty`: `stk_pop`=1, err OK.
  - POP with `stk_empty`: no strobe, err 10.
  - NOP: no strobe, err OK.
  - op 11: no strobe, err 11.
- WAIT: the stack has updated. Load `rsp_data`:
  - successful POP: `stk_dout`.
  - successful PUSH: latched data.
  - anything else: 0.
  - Then go to RSP.
- RSP: `rsp_valid`=1. `rsp_data` and `rsp_err` hold stable until `rsp_ready`. On the handshake, go to IDLE.
- Strobes are high for exactly one cycle, and only in EXEC.
- A rejected command never changes stack state.

## Timing
- Reset values: `cmd_ready`=0 during the reset cycle and 1 the cycle after.
- Reset values of all other outputs: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=00, strobes 0, `stk_din`=0, `occ`=0.
- Handshake accepted in cycle N: strobe in N+1, `rsp_valid` rises in N+3.
- Fixed latency of 3 cycles for all ops, including errors.
- With `rsp_ready` tied high, accepting in cycle N lets the next command be accepted in N+4. Peak throughput is 1 command per 4 cycles.
- `cmd_ready` is low from N+1 until the cycle after the response handshake.
- `rsp_ready` low stalls in RSP indefinitely. Outputs hold and no strobes are issued.
- `cmd_valid` asserted outside IDLE is ignored. Upstream must hold it stable until ready.
- Flags are sampled in EXEC, at least 2 cycles after any prior strobe, so they are always settled.
- `rst` mid-operation: the command is abandoned with no response. No strobe is issued in the cycle after `rst`. The stack is reset by the same reset (via its inverted reset pin), so `occ` and the stack index stay consistent.

## Configuration
- `STACK_CMD_CTRL_OCC_EN` defined: the `occ` port exists.
  - Increments on `stk_push`, decrements on `stk_pop`, range 0..DEPTH.
  - Reports the post-update value from WAIT onward.
- `STACK_CMD_CTRL_OCC_EN` undefined: no `occ` port and no counter logic. All other behaviour is identical.

## Structure
- `stack_cmd_pkg` holds:
  - op encodings: `OP_NOP`, `OP_PUSH`, `OP_POP`, `OP_ILL`.
  - error encodings: `ERR_OK`, `ERR_OVF`, `ERR_UNF`, `ERR_ILL`.
  - the FSM state typedef.
- One sub-module: `stack_cmd_occ_cnt`, the occupancy counter, instantiated only under the macro.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, with the stack instantiated below the controller.
- Reset then PUSH 0x5A: strobe 1 cycle after accept; `rsp_valid` at +3 with data 0x5A, err 00.
- Then POP: `stk_pop` 1 cycle; response data 0x5A, err 00; `occ` 1→0.
- POP on an empty stack: no `stk_pop`; response data 0x00, err 10.
- PUSH 0x01..0x08, then PUSH 0x09: ninth response err 01 with no strobe. Eight POPs then return 0x08..0x01 in order.
- op 11 with data 0xFF: err 11, data 0x00, no strobes. Then hold `rsp_ready`=0 for 5 cycles: response stable, `cmd_ready`=0.
- Assert `rst` in the EXEC cycle of a PUSH: no response. Next cycle all outputs are at reset values and `occ`=0. A following POP returns err 10.
